axi_req_beat_decoder: RTL and testbench

//  Parametrised successor to the combinational arbiter-result decoder.
//  - Accepts one packed arbiter request (read or write) per valid/ready handshake.
//  - Unpacks the AXI fields and expands the burst into per-beat addresses (FIXED/INCR/WRAP).
//  - Emits one beat per out handshake, with tag/index/offset split for the cache lookup.
//  - Sits between the request arbiter and the cache tag/data pipeline.

---
 rtl/axi_req_beat_decoder.sv | 182 ++++++++++++++++++
 tb/tb_axi_req_beat_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_req_beat_decoder.sv
// Unpacks one arbiter request (read or write layout) and sequences it as AXI beats
// (FIXED/INCR/WRAP), splitting each beat address into tag/index/offset for the cache.
module axi_req_beat_decoder #(
    parameter int REQ_W    = 128,
    parameter int ADDR_W   = 32,
    parameter int ID_W     = 4,
    parameter int DATA_W   = 64,
    parameter int OFFSET_W = 3,
    parameter int INDEX_W  = 7
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_wr,
    input  logic [REQ_W-1:0]                      in_req,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_wr,
    output logic [ADDR_W-1:0]                     out_addr,
    output logic [ID_W-1:0]                       out_id,
    output logic [2:0]                            out_size,
    output logic [7:0]                            out_beat,
    output logic                                  out_last,
    output logic [DATA_W-1:0]                     out_wdata,
    output logic [DATA_W/8-1:0]                   out_wstrb,
    output logic [ADDR_W-INDEX_W-OFFSET_W-1:0]    out_tag,
    output logic [INDEX_W-1:0]                    out_index,
    output logic [OFFSET_W-1:0]                   out_offset,
    output logic                                  out_err,
    output logic                                  dbg_state
);
    localparam int STRB_W   = DATA_W / 8;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SIZE_MAX = $clog2(STRB_W);
    localparam int WR_BASE  = DATA_W + STRB_W;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never drops and the payload never changes until that transfer has happened.
    typedef enum logic {S_IDLE = 1'b0, S_BEAT = 1'b1} state_t;
    state_t state;

    logic [ADDR_W-1:0] f_addr;
    logic [ID_W-1:0]   f_id;
    logic [1:0]        f_burst;
    logic [2:0]        f_size;
    logic [7:0]        f_len;
    logic [DATA_W-1:0] f_wdata;
    logic [STRB_W-1:0] f_wstrb;

    always_comb begin
        f_addr  = '0;
        f_id    = '0;
        f_burst = '0;
        f_size  = '0;
        f_len   = '0;
        f_wdata = '0;
        f_wstrb = '0;
        if (in_wr) begin
            f_wstrb = in_req[STRB_W-1:0];
            f_wdata = in_req[STRB_W +: DATA_W];
            f_len   = in_req[WR_BASE +: 8];
            f_size  = in_req[WR_BASE+8 +: 3];
            f_burst = in_req[WR_BASE+11 +: 2];
            f_id    = in_req[WR_BASE+13 +: ID_W];
            f_addr  = in_req[WR_BASE+13+ID_W +: ADDR_W];
        end else begin
            f_len   = in_req[7:0];
            f_size  = in_req[10:8];
            f_burst = in_req[12:11];
            f_id    = in_req[13 +: ID_W];
            f_addr  = in_req[13+ID_W +: ADDR_W];
        end
    end

    // Capture-time legality checks; illegal bursts still run, using a sane fallback.
    logic              size_big;
    logic [2:0]        cap_size;
    logic [ADDR_W-1:0] cap_step;
    logic              len_ok;
    logic              unaligned;
    logic [1:0]        cap_burst;
    logic              cap_err;

    always_comb begin
        size_big  = (f_size > 3'(SIZE_MAX));
        cap_size  = size_big ? 3'(SIZE_MAX) : f_size;
        cap_step  = ADDR_W'(1) << cap_size;
        len_ok    = (f_len == 8'd1) || (f_len == 8'd3) || (f_len == 8'd7) || (f_len == 8'd15);
        unaligned = |(f_addr & (cap_step - ADDR_W'(1)));
        cap_burst = f_burst;
        if (f_burst == BURST_RSVD || (f_burst == BURST_WRAP && !len_ok))
            cap_burst = BURST_INCR;
        cap_err = (f_burst == BURST_RSVD) || size_big ||
                  (f_burst == BURST_WRAP && (!len_ok || unaligned));
    end

    logic [1:0]        burst_q;
    logic [2:0]        size_q;
    logic [7:0]        len_q;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] next_addr;

    always_comb begin
        step      = ADDR_W'(1) << size_q;
        wrap_mask = (ADDR_W'({1'b0, len_q} + 9'd1) << size_q) - ADDR_W'(1);
        case (burst_q)
            BURST_FIXED: next_addr = out_addr;
            BURST_WRAP:  next_addr = (out_addr & ~wrap_mask) | ((out_addr + step) & wrap_mask);
            default:     next_addr = (out_addr & ~(step - ADDR_W'(1))) + step;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_wr    <= 1'b0;
            out_addr  <= '0;
            out_id    <= '0;
            out_size  <= '0;
            out_beat  <= '0;
            out_last  <= 1'b0;
            out_wdata <= '0;
            out_wstrb <= '0;
            out_err   <= 1'b0;
            burst_q   <= '0;
            size_q    <= '0;
            len_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        state     <= S_BEAT;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_wr    <= in_wr;
                        out_addr  <= f_addr;
                        out_id    <= f_id;
                        out_size  <= f_size;
                        out_beat  <= 8'd0;
                        out_last  <= (f_len == 8'd0);
                        out_wdata <= f_wdata;
                        out_wstrb <= f_wstrb;
                        out_err   <= cap_err;
                        burst_q   <= cap_burst;
                        size_q    <= cap_size;
                        len_q     <= f_len;
                    end
                end
                S_BEAT: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            state     <= S_IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            out_beat  <= out_beat + 8'd1;
                            out_last  <= ((out_beat + 8'd1) == len_q);
                            out_addr  <= next_addr;
                            out_wstrb <= '0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign out_tag    = out_addr[ADDR_W-1 -: TAG_W];
    assign out_index  = out_addr[OFFSET_W +: INDEX_W];
    assign out_offset = out_addr[OFFSET_W-1:0];
    assign dbg_state  = (state == S_BEAT);

endmodule

// File: tb/tb_axi_req_beat_decoder.sv
// Randomized and directed bench for axi_req_beat_decoder; beat addresses come from an
// arithmetic burst model and every output is compared per beat.
module tb_axi_req_beat_decoder;
    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_wr;
    logic [127:0] in_req;
    logic         out_valid;
    logic         out_ready;
    logic         out_wr;
    logic [31:0]  out_addr;
    logic [3:0]   out_id;
    logic [2:0]   out_size;
    logic [7:0]   out_beat;
    logic         out_last;
    logic [63:0]  out_wdata;
    logic [7:0]   out_wstrb;
    logic [21:0]  out_tag;
    logic [6:0]   out_index;
    logic [2:0]   out_offset;
    logic         out_err;
    logic         dbg_state;

    axi_req_beat_decoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_wr(in_wr), .in_req(in_req),
        .out_valid(out_valid), .out_ready(out_ready), .out_wr(out_wr),
        .out_addr(out_addr), .out_id(out_id), .out_size(out_size), .out_beat(out_beat),
        .out_last(out_last), .out_wdata(out_wdata), .out_wstrb(out_wstrb),
        .out_tag(out_tag), .out_index(out_index), .out_offset(out_offset),
        .out_err(out_err), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Next beat address straight from the AXI burst rules, in plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] a, input int burst,
                                               input int size, input int len);
        longint unsigned ua, n, blk, base, r;
        ua = a;
        n  = 64'd1 << size;
        if (burst == 0) return a;
        if (burst == 2) begin
            blk  = (len + 1) * n;
            base = ua - (ua % blk);
            r    = base + ((ua + n) % blk);
        end else begin
            r = ((ua - (ua % n)) + n) % 64'h1_0000_0000;
        end
        return r[31:0];
    endfunction

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [3:0] id,
                          input logic [1:0] burst, input logic [2:0] size, input logic [7:0] len,
                          input logic [63:0] wdata, input logic [7:0] wstrb,
                          input int max_stall, input bit poke);
        int esize, eburst, n, stall, waited;
        bit len_ok, eerr;
        logic [31:0]  a;
        logic [127:0] req;
        esize  = (size > 3) ? 3 : int'(size);
        n      = 1 << esize;
        len_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
        eerr   = (burst == 3) || (size > 3) || (burst == 2 && (!len_ok || (addr % n) != 0));
        eburst = (burst == 3 || (burst == 2 && !len_ok)) ? 1 : int'(burst);
        exp_q.delete();
        a = addr;
        for (int b = 0; b <= int'(len); b++) begin
            exp_q.push_back(a);
            a = model_next(a, eburst, esize, len);
        end
        req = {$urandom, $urandom, $urandom, $urandom};
        if (wr) req[120:0] = {addr, id, burst, size, len, wdata, wstrb};
        else    req[48:0]  = {addr, id, burst, size, len};

        @(negedge clk);
        in_wr = wr; in_req = req; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_val("accept_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_val("busy_in_ready", in_ready, 1'b0);

        for (int b = 0; b <= int'(len); b++) begin
            out_ready = 1'b0;
            stall = (poke && b == 1) ? 5 : $urandom_range(0, max_stall);
            for (int s = 0; s < stall; s++) begin
                if (poke) begin
                    in_valid = 1'b1;
                    in_req   = {$urandom, $urandom, $urandom, $urandom};
                end
                @(negedge clk);
                check_val("stall_in_ready", in_ready, 1'b0);
                check_val("stall_beat", out_beat, b);
                check_val("stall_addr", out_addr, exp_q[b]);
            end
            in_valid = 1'b0;
            check_val("valid", out_valid, 1'b1);
            check_val("addr", out_addr, exp_q[b]);
            check_val("id", out_id, id);
            check_val("size", out_size, size);
            check_val("beat", out_beat, b);
            check_val("last", out_last, b == int'(len));
            check_val("wr", out_wr, wr);
            check_val("wdata", out_wdata, wr ? wdata : 64'd0);
            check_val("wstrb", out_wstrb, (wr && b == 0) ? wstrb : 8'd0);
            check_val("tag", out_tag, exp_q[b] / 1024);
            check_val("index", out_index, (exp_q[b] / 8) % 128);
            check_val("offset", out_offset, exp_q[b] % 8);
            check_val("err", out_err, eerr);
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check_val("done_valid", out_valid, 1'b0);
        check_val("done_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [1:0]  r_burst;
        logic [2:0]  r_size;
        logic [7:0]  r_len;
        logic [31:0] r_addr;
        int pick;

        rst_n = 1'b0; in_valid = 1'b0; in_wr = 1'b0; in_req = '0; out_ready = 1'b0;
        #12;
        check_val("rst_valid", out_valid, 1'b0);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_addr", out_addr, 32'd0);
        check_val("rst_err", out_err, 1'b0);
        check_val("rst_last", out_last, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b0, 32'h1000, 4'h3, 2'b01, 3'd3, 8'd3, 64'd0, 8'd0, 0, 1'b0);
        do_req(1'b0, 32'h1018, 4'h7, 2'b10, 3'd3, 8'd3, 64'd0, 8'd0, 0, 1'b0);
        do_req(1'b1, 32'h2004, 4'h5, 2'b00, 3'd2, 8'd2, 64'hDEADBEEF_CAFEF00D, 8'hF0, 0, 1'b0);
        do_req(1'b0, 32'h4000, 4'h1, 2'b01, 3'd2, 8'd3, 64'd0, 8'd0, 0, 1'b1);
        do_req(1'b0, 32'h5000, 4'h2, 2'b11, 3'd2, 8'd1, 64'd0, 8'd0, 0, 1'b0);
        do_req(1'b1, 32'h5000, 4'h9, 2'b01, 3'd4, 8'd2, 64'h1234, 8'hFF, 0, 1'b0);
        do_req(1'b0, 32'h1004, 4'h4, 2'b10, 3'd3, 8'd3, 64'd0, 8'd0, 0, 1'b0);
        do_req(1'b0, 32'h6000, 4'h6, 2'b10, 3'd2, 8'd2, 64'd0, 8'd0, 0, 1'b0);
        do_req(1'b0, 32'hFFFF_FFF8, 4'hA, 2'b01, 3'd3, 8'd1, 64'd0, 8'd0, 0, 1'b0);
        do_req(1'b1, 32'h7003, 4'hB, 2'b01, 3'd0, 8'd0, 64'h55, 8'h01, 0, 1'b0);

        // Reset in the middle of beat 2 of a len 7 INCR burst.
        @(negedge clk);
        in_wr = 1'b0; in_req = '0; in_req[48:0] = {32'h3000, 4'h2, 2'b01, 3'd3, 8'd7};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val("mid_beat", out_beat, 8'd2);
        check_val("mid_addr", out_addr, 32'h3010);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_valid", out_valid, 1'b0);
        check_val("arst_in_ready", in_ready, 1'b1);
        check_val("arst_addr", out_addr, 32'd0);
        check_val("arst_beat", out_beat, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_valid", out_valid, 1'b0);
        check_val("post_rst_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 40; i++) begin
            r_burst = 2'($urandom_range(0, 3));
            r_size  = 3'(($urandom_range(0, 7) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3));
            pick    = $urandom_range(0, 5);
            case (pick)
                0: r_len = 8'd0;
                1: r_len = 8'd1;
                2: r_len = 8'd3;
                3: r_len = 8'd7;
                4: r_len = 8'd15;
                default: r_len = 8'($urandom_range(0, 20));
            endcase
            r_addr = $urandom;
            if (r_burst == 2'b10 && $urandom_range(0, 3) != 0)
                r_addr = r_addr & ~32'(((r_size > 3) ? 8 : (1 << r_size)) - 1);
            do_req(1'($urandom_range(0, 1)), r_addr, 4'($urandom_range(0, 15)), r_burst, r_size,
                   r_len, {$urandom, $urandom}, 8'($urandom_range(0, 255)), 3,
                   1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
